trg_mon_readout: RTL
====================

TRG_MON_READOUT -- requirements
Module: trg_mon_readout

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, monitor word width.
REQ-002 The block SHALL have parameter N_REGS, default 48, number of monitor words on the input bus (1..2^ADDR_W).
REQ-003 The block SHALL have parameter ADDR_W, default 8, address and length width.
REQ-004 The block SHALL have parameter FILL_WORD, default 16'hEB90, value returned for out-of-range addresses.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 The block SHALL have port clk_in, input, 1, system clock (50 MHz).
REQ-007 The block SHALL have port rst_in_N, input, 1, synchronous active-low reset.
REQ-008 The block SHALL have port rd_in, input, 1, read request (one-cycle strobe).
REQ-009 The block SHALL have port rd_addr_in, input, ADDR_W, burst start address.
REQ-010 The block SHALL have port rd_len_in, input, ADDR_W, burst word count (0 treated as 1).
REQ-011 The block SHALL have port rd_abort_in, input, 1, terminate burst.
REQ-012 The block SHALL have port mon_bus_in, input, N_REGS*DATA_W, flattened live monitor words; word k = bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port mon_ready_in, input, 1, consumer ready.
REQ-014 The block SHALL have port mon_data_out, output, DATA_W, current word.
REQ-015 The block SHALL have port mon_valid_out, output, 1, word valid.
REQ-016 The block SHALL have port mon_last_out, output, 1, final word of burst.
REQ-017 The block SHALL have port mon_err_out, output, 1, current word is out-of-range (FILL_WORD).
REQ-018 The block SHALL have port busy_out, output, 1, burst in progress.
REQ-019 The block SHALL have port rd_drop_cnt_out, output, 16, count of rejected rd_in.

Function
REQ-020 FSM states SHALL be IDLE, LOAD and SEND; busy_out = (state != IDLE).
REQ-021 IDLE with rd_in=1 SHALL capture all of mon_bus_in into a shadow bank in that edge, latch cur_addr=rd_addr_in and remaining=max(rd_len_in,1), and go to LOAD; multi-word counters are thereby coherent across the burst.
REQ-022 LOAD SHALL register shadow[cur_addr] into mon_data_out and go to SEND; first mon_valid_out SHALL occur 2 cycles after the rd_in edge.
REQ-023 In SEND, mon_valid_out=1 and mon_data_out, mon_err_out and mon_last_out SHALL stay stable until mon_valid_out&mon_ready_in.
REQ-024 On a handshake with remaining>1, the block SHALL decrement remaining, set cur_addr=cur_addr+1 modulo 2^ADDR_W, and load the next word on the same edge; valid SHALL stay high (one word per cycle sustained).
REQ-025 On a handshake with remaining==1, the block SHALL return to IDLE and deassert mon_valid_out on the next edge.
REQ-026 mon_last_out SHALL equal (remaining==1) while in SEND, and 0 otherwise.
REQ-027 Address >= N_REGS SHALL yield mon_data_out=FILL_WORD with mon_err_out=1 for that word only; the burst SHALL continue.
REQ-028 rd_in while busy_out=1 SHALL be ignored and SHALL increment rd_drop_cnt_out, saturating at 16'hFFFF.
REQ-029 rd_abort_in in LOAD or SEND SHALL force IDLE next edge, with valid and last cleared; abort SHALL have priority over a same-cycle handshake (word not counted as delivered).
REQ-030 rd_in and rd_abort_in in the same IDLE cycle SHALL start the burst (abort has no effect in IDLE).
REQ-031 In IDLE, mon_data_out SHALL hold the last loaded value.

Reset
REQ-032 rst_in_N=0 at a clock edge SHALL force state IDLE; mon_data_out=0, mon_valid_out=0, mon_last_out=0, mon_err_out=0, busy_out=0, rd_drop_cnt_out=0, shadow bank=0.
REQ-033 Reset mid-burst SHALL drop valid on that edge with no further words; the first rd_in after release SHALL behave as from power-up.

Structure
REQ-034 Shared package trg_mon_pkg SHALL hold the FSM state enum, the FILL_WORD default and the drop-counter width (16).
REQ-035 The shadow bank plus indexed read mux with range check SHALL be sub-module trg_mon_shadow (capture enable, read address in; word and err out); FSM/handshake SHALL live in the top module.

Verification
REQ-036 Scenario: word 14=16'h0001, word 15=16'hFFFF; rd_addr=14, len=2, ready=1; bus changes after the rd_in edge -> 16'h0001 then 16'hFFFF, last on the second word, valid 2 cycles after rd_in.
REQ-037 Scenario: len=4 from address 3 with ready toggling 1,0,0,1,1,0,1 -> exactly 4 words 3..6 in order, data held during stalls.
REQ-038 Scenario: N_REGS=48, addr=46, len=4 -> words 46, 47, FILL_WORD 16'hEB90 (err=1), FILL_WORD (err=1, last=1).
REQ-039 Scenario: addr=255, len=2, ADDR_W=8 -> address 255 (FILL, err=1) then wrap to word 0.
REQ-040 Scenario: 3 rd_in pulses during a burst -> rd_drop_cnt_out=3, burst unaffected; abort on the 2nd handshake cycle -> valid low the next cycle, busy_out=0.
REQ-041 Scenario: rst_in_N=0 mid-burst -> all outputs 0 on that edge; a new rd_in after release yields the correct first word.

Source files
------------

// File: rtl/trg_mon_pkg.sv
// Shared types and constants for the trigger monitor readout block.
package trg_mon_pkg;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Word returned for addresses beyond the populated monitor range.
  localparam logic [15:0] FILL_WORD_DEF = 16'hEB90;

  // Width of the rejected-request counter.
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/trg_mon_shadow.sv
// Shadow bank: snapshots the whole live monitor bus on request so that a
// multi-word burst reads one coherent set of values, and provides an indexed
// read with an out-of-range flag.
module trg_mon_shadow
  import trg_mon_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                N_REGS    = 48,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF)
) (
  input  logic                     clk_in,
  input  logic                     rst_in_N,
  input  logic                     cap_en,
  input  logic [N_REGS*DATA_W-1:0] bus,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        word,
  output logic                     err
);

  logic [N_REGS*DATA_W-1:0] shadow_q;

  // Snapshot the full monitor bus when a burst is accepted.
  // NOTE: the bank is reset on purpose: after reset a read must return zeros,
  // never words left over from before the reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments for all clocked state, so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_in_N) begin
      shadow_q <= '0;
    end else if (cap_en) begin
      shadow_q <= bus;
    end
  end

  // Indexed read; anything at or beyond N_REGS returns the fill pattern.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    word = FILL_WORD;
    err  = 1'b1;
    for (int k = 0; k < N_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
        word = shadow_q[k*DATA_W +: DATA_W];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trg_mon_readout.sv
// Trigger monitor readout: accepts a burst request, snapshots the monitor
// bus, then streams the requested words over a valid/ready interface.
module trg_mon_readout
  import trg_mon_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                N_REGS    = 48,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF)
) (
  input  logic                     clk_in,
  input  logic                     rst_in_N,
  input  logic                     rd_in,
  input  logic [ADDR_W-1:0]        rd_addr_in,
  input  logic [ADDR_W-1:0]        rd_len_in,
  input  logic                     rd_abort_in,
  input  logic [N_REGS*DATA_W-1:0] mon_bus_in,
  input  logic                     mon_ready_in,
  output logic [DATA_W-1:0]        mon_data_out,
  output logic                     mon_valid_out,
  output logic                     mon_last_out,
  output logic                     mon_err_out,
  output logic                     busy_out,
  output logic [DROP_CNT_W-1:0]    rd_drop_cnt_out
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cur_addr_q;
  logic [ADDR_W-1:0]     remain_q;
  logic [DATA_W-1:0]     data_q;
  logic                  err_q;
  logic [DROP_CNT_W-1:0] drop_q;

  logic                  in_send;
  logic                  hs;
  logic                  last_word;
  logic [ADDR_W-1:0]     rd_sel;
  logic [DATA_W-1:0]     sh_word;
  logic                  sh_err;

  assign in_send   = (state_q == ST_SEND);
  assign hs        = in_send && mon_ready_in;
  assign last_word = (remain_q == ADDR_W'(1));
  // In SEND the mux looks one word ahead so the next word loads on the
  // handshake edge and throughput stays at one word per cycle.
  assign rd_sel    = in_send ? cur_addr_q + ADDR_W'(1) : cur_addr_q;

  trg_mon_shadow #(
    .DATA_W    (DATA_W),
    .N_REGS    (N_REGS),
    .ADDR_W    (ADDR_W),
    .FILL_WORD (FILL_WORD)
  ) u_shadow (
    .clk_in   (clk_in),
    .rst_in_N (rst_in_N),
    .cap_en   ((state_q == ST_IDLE) && rd_in),
    .bus      (mon_bus_in),
    .rd_addr  (rd_sel),
    .word     (sh_word),
    .err      (sh_err)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in_N) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; abort beats a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd_in) state_d = ST_LOAD;
      ST_LOAD: state_d = rd_abort_in ? ST_IDLE : ST_SEND;
      ST_SEND: begin
        if (rd_abort_in)          state_d = ST_IDLE;
        else if (hs && last_word) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping and output word register.
  always_ff @(posedge clk_in) begin
    if (!rst_in_N) begin
      cur_addr_q <= '0;
      remain_q   <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_in) begin
            cur_addr_q <= rd_addr_in;
            remain_q   <= (rd_len_in == '0) ? ADDR_W'(1) : rd_len_in;
          end
        end
        ST_LOAD: begin
          if (!rd_abort_in) begin
            data_q <= sh_word;
            err_q  <= sh_err;
          end
        end
        ST_SEND: begin
          if (!rd_abort_in && hs && !last_word) begin
            remain_q   <= remain_q - ADDR_W'(1);
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            data_q     <= sh_word;
            err_q      <= sh_err;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of requests rejected because a burst was in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in_N) begin
      drop_q <= '0;
    end else if (rd_in && (state_q != ST_IDLE) && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  assign mon_data_out    = data_q;
  assign mon_valid_out   = in_send;
  assign mon_last_out    = in_send && last_word;
  assign mon_err_out     = in_send && err_q;
  assign busy_out        = (state_q != ST_IDLE);
  assign rd_drop_cnt_out = drop_q;

endmodule
